// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell encodings, board geometry, direction deltas
// and the capture-stage FSM states.
package reversi_pkg;

  localparam int DIM       = 8;
  localparam int CELL_W    = 3;
  localparam int NUM_CELLS = DIM * DIM;
  localparam int BOARD_W   = NUM_CELLS * CELL_W;

  localparam logic [2:0] CELL_EMPTY = 3'b000;
  localparam logic [2:0] CELL_WHITE = 3'b110;
  localparam logic [2:0] CELL_BLACK = 3'b111;

  // Two's-complement deltas for N, NE, E, SE, S, SW, W, NW (2'b11 = -1)
  localparam logic [1:0] DR [8] = '{2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11};
  localparam logic [1:0] DC [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b11};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/flip_discs_if.sv
// Request/response bundle between the placement stage and the capture stage.
interface flip_discs_if;
  import reversi_pkg::*;

  logic               start;
  logic [BOARD_W-1:0] board_in;
  logic [5:0]         index;
  logic               player_black;
  logic               busy;
  logic               done;
  logic [BOARD_W-1:0] board_out;
  logic [5:0]         flip_count;
  logic               legal;

  modport master (
    output start, board_in, index, player_black,
    input  busy, done, board_out, flip_count, legal
  );

  modport slave (
    input  start, board_in, index, player_black,
    output busy, done, board_out, flip_count, legal
  );

endinterface

// File: rtl/reversi_dir_step.sv
// One step from (row, col) along direction dir; flags steps that leave the 8x8 board.
module reversi_dir_step
  import reversi_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  logic [2:0] dir,
  output logic [2:0] next_row,
  output logic [2:0] next_col,
  output logic       off_board
);

  logic [4:0] row_sum;
  logic [4:0] col_sum;

  // Row/col range -1..8: bit 4 catches -1, bit 3 catches 8, so no wrap across rows
  assign row_sum   = {2'b00, row} + {{3{DR[dir][1]}}, DR[dir]};
  assign col_sum   = {2'b00, col} + {{3{DC[dir][1]}}, DC[dir]};
  assign next_row  = row_sum[2:0];
  assign next_col  = col_sum[2:0];
  assign off_board = row_sum[4] | row_sum[3] | col_sum[4] | col_sum[3];

endmodule

// File: rtl/flip_discs.sv
// Capture stage: walks the 8 directions from the placed cell, one cell per cycle,
// and flips every bracketed opponent disc to the mover's colour.
module flip_discs
  import reversi_pkg::*;
(
  input  logic         clk,
  input  logic         reseten,
  flip_discs_if.slave  bus
);

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [5:0]           idx_q, idx_d;
  logic                 black_q, black_d;
  logic [2:0]           dir_q, dir_d;
  logic [2:0]           cur_row_q, cur_row_d;
  logic [2:0]           cur_col_q, cur_col_d;
  logic                 cur_off_q, cur_off_d;
  logic [NUM_CELLS-1:0] pend_q, pend_d;
  logic [NUM_CELLS-1:0] flip_q, flip_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 legal_q, legal_d;
  logic [5:0]           count_q, count_d;
  logic [BOARD_W-1:0]   board_out_q, board_out_d;

  logic [2:0]           cur_next_row, cur_next_col;
  logic                 cur_next_off;
  logic [2:0]           idx_row_sel, idx_col_sel, idx_dir_sel;
  logic [2:0]           idx_next_row, idx_next_col;
  logic                 idx_next_off;
  logic [7:0]           bit_base;
  logic [2:0]           cur_cell;
  logic [NUM_CELLS-1:0] cur_bit;
  logic [BOARD_W-1:0]   resolved;
  logic [5:0]           flips;
  logic                 end_dir;

  // Steps the cursor along the current direction
  reversi_dir_step u_step_cur (
    .row       (cur_row_q),
    .col       (cur_col_q),
    .dir       (dir_q),
    .next_row  (cur_next_row),
    .next_col  (cur_next_col),
    .off_board (cur_next_off)
  );

  // First cell of a new direction: from the incoming index on start, else the latched one
  assign idx_row_sel = (state_q == IDLE) ? bus.index[5:3] : idx_q[5:3];
  assign idx_col_sel = (state_q == IDLE) ? bus.index[2:0] : idx_q[2:0];
  assign idx_dir_sel = (state_q == IDLE) ? 3'd0 : dir_q + 3'd1;

  reversi_dir_step u_step_idx (
    .row       (idx_row_sel),
    .col       (idx_col_sel),
    .dir       (idx_dir_sel),
    .next_row  (idx_next_row),
    .next_col  (idx_next_col),
    .off_board (idx_next_off)
  );

  assign bit_base = {2'b00, cur_row_q, cur_col_q} * 8'd3;
  assign cur_cell = board_q[bit_base +: CELL_W];
  assign cur_bit  = {{(NUM_CELLS-1){1'b0}}, 1'b1} << {cur_row_q, cur_col_q};

  always_comb begin
    resolved = board_q;
    flips    = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (flip_q[i]) resolved[CELL_W*i +: CELL_W] = black_q ? CELL_BLACK : CELL_WHITE;
      flips = flips + {5'b00000, flip_q[i]};
    end
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    idx_d       = idx_q;
    black_d     = black_q;
    dir_d       = dir_q;
    cur_row_d   = cur_row_q;
    cur_col_d   = cur_col_q;
    cur_off_d   = cur_off_q;
    pend_d      = pend_q;
    flip_d      = flip_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    legal_d     = legal_q;
    count_d     = count_q;
    board_out_d = board_out_q;
    end_dir     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          board_d   = bus.board_in;
          idx_d     = bus.index;
          black_d   = bus.player_black;
          dir_d     = 3'd0;
          cur_row_d = idx_next_row;
          cur_col_d = idx_next_col;
          cur_off_d = idx_next_off;
          pend_d    = '0;
          flip_d    = '0;
          busy_d    = 1'b1;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (cur_off_q || !cur_cell[2]) begin
          pend_d  = '0;
          end_dir = 1'b1;
        end else if (cur_cell[0] != black_q) begin
          pend_d    = pend_q | cur_bit;
          cur_row_d = cur_next_row;
          cur_col_d = cur_next_col;
          cur_off_d = cur_next_off;
        end else begin
          flip_d  = flip_q | pend_q;
          pend_d  = '0;
          end_dir = 1'b1;
        end
        if (end_dir) begin
          if (dir_q == 3'd7) begin
            state_d = COMMIT;
          end else begin
            dir_d     = dir_q + 3'd1;
            cur_row_d = idx_next_row;
            cur_col_d = idx_next_col;
            cur_off_d = idx_next_off;
          end
        end
      end
      COMMIT: begin
        board_out_d = resolved;
        count_d     = flips;
        legal_d     = (flip_q != '0);
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reseten) begin
      state_q     <= IDLE;
      board_q     <= '0;
      idx_q       <= '0;
      black_q     <= 1'b0;
      dir_q       <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      cur_off_q   <= 1'b0;
      pend_q      <= '0;
      flip_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      legal_q     <= 1'b0;
      count_q     <= '0;
      board_out_q <= '0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      idx_q       <= idx_d;
      black_q     <= black_d;
      dir_q       <= dir_d;
      cur_row_q   <= cur_row_d;
      cur_col_q   <= cur_col_d;
      cur_off_q   <= cur_off_d;
      pend_q      <= pend_d;
      flip_q      <= flip_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      legal_q     <= legal_d;
      count_q     <= count_d;
      board_out_q <= board_out_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.legal      = legal_q;
  assign bus.flip_count = count_q;
  assign bus.board_out  = board_out_q;

endmodule

// File: tb/tb_flip_discs.sv
// Scoreboard bench for flip_discs: directed boards with hand-computed results and
// latencies (edges from the accepting edge to the done edge = SCAN cycles + 1).
module tb_flip_discs;
  import reversi_pkg::*;

  logic clk = 1'b0;
  logic reseten;

  flip_discs_if bus();

  flip_discs dut (
    .clk     (clk),
    .reseten (reseten),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;

  typedef struct {
    logic [BOARD_W-1:0] board;
    logic [5:0]         count;
    logic               legal;
    int                 start_cyc;
    int                 lat;
  } exp_t;

  exp_t sb[$];

  localparam logic [2:0] W = CELL_WHITE;
  localparam logic [2:0] B = CELL_BLACK;

  logic [BOARD_W-1:0] b1, e1, b2, e2, b3, e3, b4, e4;

  function automatic logic [BOARD_W-1:0] putCell(input logic [BOARD_W-1:0] b, input int i,
                                                 input logic [2:0] c);
    b[CELL_W*i +: CELL_W] = c;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [BOARD_W-1:0] act,
                             input logic [BOARD_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Caller is positioned away from the rising edge; start is sampled at the next one
  task automatic applyStimulus(input logic [BOARD_W-1:0] b, input logic [5:0] idx,
                               input logic blk, input logic [BOARD_W-1:0] exp_b,
                               input logic [5:0] exp_n, input logic exp_legal,
                               input int exp_lat);
    exp_t e;
    bus.start        = 1'b1;
    bus.board_in     = b;
    bus.index        = idx;
    bus.player_black = blk;
    @(posedge clk);
    #1;
    e.board     = exp_b;
    e.count     = exp_n;
    e.legal     = exp_legal;
    e.start_cyc = cyc;
    e.lat       = exp_lat;
    sb.push_back(e);
    bus.start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 192'(n < 100), 192'(1));
  endtask

  // Monitor: pops the oldest expectation on every done pulse
  initial begin
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        done_count++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0 cycle=%0d", cyc);
        end else begin
          e   = sb.pop_front();
          lat = cyc - e.start_cyc;
          checkOutput("board_out", bus.board_out, e.board);
          checkOutput("flip_count", 192'(bus.flip_count), 192'(e.count));
          checkOutput("legal", 192'(bus.legal), 192'(e.legal));
          checkOutput("latency", 192'(lat), 192'(e.lat));
          checkOutput("latency_le_58", 192'(lat <= 58), 192'(1));
        end
      end
    end
  end

  initial begin
    bus.start        = 1'b0;
    bus.board_in     = '0;
    bus.index        = '0;
    bus.player_black = 1'b0;
    reseten          = 1'b0;

    b1 = '0;
    b1 = putCell(b1, 35, B);
    b1 = putCell(b1, 27, W);
    b1 = putCell(b1, 19, B);
    e1 = putCell(b1, 27, B);

    b2 = '0;
    b2 = putCell(b2, 0, W);
    b2 = putCell(b2, 1, B);
    b2 = putCell(b2, 2, B);
    b2 = putCell(b2, 9, B);
    b2 = putCell(b2, 18, B);
    b2 = putCell(b2, 3, W);
    b2 = putCell(b2, 27, W);
    e2 = putCell(b2, 1, W);
    e2 = putCell(e2, 2, W);
    e2 = putCell(e2, 9, W);
    e2 = putCell(e2, 18, W);

    b3 = '0;
    b3 = putCell(b3, 24, B);
    for (int i = 25; i <= 31; i++) b3 = putCell(b3, i, W);
    e3 = b3;

    b4 = '0;
    b4 = putCell(b4, 7, W);
    b4 = putCell(b4, 8, B);
    b4 = putCell(b4, 9, W);
    e4 = b4;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 192'(bus.busy), 192'(0));
    checkOutput("reset_done", 192'(bus.done), 192'(0));
    checkOutput("reset_legal", 192'(bus.legal), 192'(0));
    checkOutput("reset_flip_count", 192'(bus.flip_count), 192'(0));
    checkOutput("reset_board_out", bus.board_out, '0);
    @(negedge clk);
    reseten = 1'b1;

    @(negedge clk);
    applyStimulus(b2, 6'd0, 1'b0, e2, 6'd4, 1'b1, 13);
    waitDone("t2_timeout");
    @(negedge clk);
    applyStimulus(b4, 6'd7, 1'b0, e4, 6'd0, 1'b0, 9);
    waitDone("t4_timeout");
    @(negedge clk);
    applyStimulus(b1, 6'd19, 1'b1, e1, 6'd1, 1'b1, 10);
    waitDone("t1_timeout");

    // Reset lands on the 5th SCAN cycle of a fresh operation
    @(negedge clk);
    applyStimulus(b2, 6'd0, 1'b0, e2, 6'd4, 1'b1, 13);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reseten = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("midreset_busy", 192'(bus.busy), 192'(0));
    checkOutput("midreset_done", 192'(bus.done), 192'(0));
    checkOutput("midreset_legal", 192'(bus.legal), 192'(0));
    checkOutput("midreset_flip_count", 192'(bus.flip_count), 192'(0));
    checkOutput("midreset_board_out", bus.board_out, '0);
    @(negedge clk);
    reseten = 1'b1;
    repeat (30) @(negedge clk);

    applyStimulus(b3, 6'd24, 1'b1, e3, 6'd0, 1'b0, 16);
    waitDone("t3_timeout");

    // start while busy is dropped; start in the done cycle is taken
    @(negedge clk);
    applyStimulus(b1, 6'd19, 1'b1, e1, 6'd1, 1'b1, 10);
    repeat (3) @(negedge clk);
    checkOutput("busy_while_scanning", 192'(bus.busy), 192'(1));
    bus.start        = 1'b1;
    bus.board_in     = b2;
    bus.index        = 6'd0;
    bus.player_black = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("t6a_timeout");
    checkOutput("busy_in_done_cycle", 192'(bus.busy), 192'(0));
    applyStimulus(b4, 6'd7, 1'b0, e4, 6'd0, 1'b0, 9);
    waitDone("t6b_timeout");

    repeat (70) @(negedge clk);
    checkOutput("scoreboard_empty", 192'(sb.size()), 192'(0));
    checkOutput("done_count", 192'(done_count), 192'(6));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
